raw_bayer_pattern_gen: RTL
==========================

# raw_bayer_pattern_gen

Synthetic raw-Bayer AXI4-Stream video source that drives the ISP pipeline input in place of the sensor/MIPI receiver. It emits 10-bit Bayer frames packed four pixels per 40-bit beat, with frame start on tuser, end of line on tlast and a fixed tdest. It provides deterministic, sensor-independent stimulus for black-level, demosaic, AWB, gamma and colour-adjust bring-up on hardware and in simulation.

## Interface
- IMG_WIDTH, 1920, active pixels per line; multiple of 32
- IMG_HEIGHT, 1080, active lines per frame; even
- BAYER_MODE, "BGGR", CFA order: "BGGR", "RGGB", "GRBG" or "GBRG"
- H_BLANK, 16, idle cycles after each accepted tlast beat; 0 allowed
- V_BLANK, 1000, idle cycles after the last line of a frame, before the next frame's tuser beat
- TDEST, 0, constant value driven on O_tdest
---
- I_clk  in  1  video clock
- I_rst_n  in  1  asynchronous reset, active low
- I_enable  in  1  run request; sampled only at frame boundaries
- I_pattern  in  2  0 colour bars, 1 ramp, 2 checker, 3 flat; latched at frame start
- O_tdata  out  40  four pixels; pixel x+0 in [9:0], x+3 in [39:30]
- O_tvalid  out  1  beat valid
- O_tready  in  1  downstream ready
- O_tuser  out  1  first beat of frame
- O_tlast  out  1  last beat of line
- O_tdest  out  10  constant TDEST
- O_frame_cnt  out  16  count of completed frames; wraps

## Operation
- FSM states: IDLE, ACTIVE, HBLANK, VBLANK.
- IDLE: if I_enable=1, latch I_pattern, clear x and y, go to ACTIVE.
- ACTIVE: present a beat. Hold it until O_tvalid&&O_tready. On accept, advance x by 4.
  - Last beat of a line that is not the last line: go to HBLANK.
  - Last beat of the last line: O_frame_cnt +1, go to VBLANK.
- HBLANK: count H_BLANK cycles, then return to ACTIVE with y+1 and x=0. The count is not gated by O_tready. If H_BLANK=0, the next line's first beat follows in the next cycle.
- VBLANK: count V_BLANK cycles.
  - Then, if I_enable=1: latch I_pattern, go to ACTIVE (new frame).
  - Otherwise go to IDLE.
- Deasserting I_enable mid-frame never truncates a frame.
- AXI rules:
  - O_tdata, O_tuser and O_tlast stay stable while O_tvalid=1 and O_tready=0.
  - O_tvalid never drops without a handshake.
- O_tuser=1 only when x=0, y=0. O_tlast=1 only when x=IMG_WIDTH-4.
- Per-pixel value p(x,y) is 10 bits:
  - Colour bars: 8 bars, each IMG_WIDTH/8 wide, in the order white, yellow, cyan, green, magenta, red, blue, black. Each component is 1023 or 0. The CFA site given by (y&1, x&1) and BAYER_MODE selects R, G or B. For BGGR: even row B,G; odd row G,R.
  - Ramp: (x+y) mod 1024.
  - Checker: 1023 if (x[5]^y[5]), else 0.
  - Flat: 512.
- Width rules: x counter 12 bits, y counter 11 bits. The ramp sum truncates to 10 bits. Bar index = x / (IMG_WIDTH/8), computed by a constant-divisor compare chain (no divider).

## Timing
- Reset values: O_tvalid=0, O_tuser=0, O_tlast=0, O_tdata=0, O_frame_cnt=0, O_tdest=TDEST; state IDLE.
- All outputs are registered.
- Start latency: if I_enable is first seen high by IDLE on edge N, O_tvalid=1 with O_tuser=1 from edge N+1.
- Throughput: one beat per cycle while O_tready=1 within a line.
- Line period: IMG_WIDTH/4 + H_BLANK cycles, given constant ready.
- Reset assertion mid-frame: outputs clear immediately (asynchronously). After release, the next frame starts fresh with tuser.
- Simultaneous tlast-accept and I_enable fall: the current frame completes normally.

## Structure
- Shared package isp_pkg:
  - pattern encodings PAT_BARS/PAT_RAMP/PAT_CHECK/PAT_FLAT
  - 10-bit bar RGB constants
  - CFA-site decode function (BAYER_MODE, y&1, x&1 → R/G/B)
- Sub-module bayer_pattern_pixel: combinational (x, y, pattern) → 10-bit value, instantiated four times for lanes x+0..x+3.
- The top holds the FSM, counters, latched pattern and output registers.

## Test plan
- Reset, I_enable=1, I_pattern=3, O_tready=1 → after one cycle, first beat tdata=40'h80_2008_0200 with tuser=1. Per line: 480 beats, 1 tlast. 1080 tlast per frame; O_frame_cnt=1 after the frame.
- Bars, BGGR, y=0, x=0 → tdata lanes {G,B,G,B} = {1023,1023,1023,1023}. At x=1680 (black bar), all lanes 0. On odd rows in the red bar, R sites are 1023 and G sites 0.
- Ramp, random O_tready (50%) → data, tuser and tlast are held stable while stalled. Pixel (x,y) equals (x+y)&1023, including the wrap at x+y=1024.
- H_BLANK=0 with ready constant → the next line's first beat immediately follows the tlast handshake. H_BLANK=16 → exactly 16 idle cycles.
- I_enable dropped at mid-frame line 500 → the frame completes all 1080 lines, then FSM goes to IDLE and no further tuser appears. I_pattern changed mid-frame → takes effect only at the next tuser.
- I_rst_n pulsed low at line 300 → O_tvalid=0 in the same cycle. After release with I_enable=1, the next beat has tuser=1 and x=y=0.

Source files
------------

// File: rtl/isp_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// isp_pkg: shared pattern encodings, bar colour masks and CFA-site decode.
// Rev 1.0
// ----------------------------------------------------------------------------
package isp_pkg;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_FLAT  = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    CFA_R = 2'd0,
    CFA_G = 2'd1,
    CFA_B = 2'd2
  } cfa_e;

  localparam logic [9:0] PIX_ON   = 10'd1023;
  localparam logic [9:0] PIX_OFF  = 10'd0;
  localparam logic [9:0] PIX_FLAT = 10'd512;

  // Bit i set means the component is lit in bar i (white, yellow, cyan, green,
  // magenta, red, blue, black).
  localparam logic [7:0] BAR_R_MASK = 8'h33;
  localparam logic [7:0] BAR_G_MASK = 8'h0F;
  localparam logic [7:0] BAR_B_MASK = 8'h55;

  // BAYER_MODE is a 4-character string read row-major over the 2x2 CFA tile.
  function automatic cfa_e cfa_site(input logic [31:0] mode, input logic y_odd,
                                    input logic x_odd);
    logic [7:0] c;
    cfa_e       site;
    unique case ({y_odd, x_odd})
      2'b00:   c = mode[31:24];
      2'b01:   c = mode[23:16];
      2'b10:   c = mode[15:8];
      default: c = mode[7:0];
    endcase
    if (c == "R")      site = CFA_R;
    else if (c == "G") site = CFA_G;
    else               site = CFA_B;
    return site;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bayer_pattern_pixel.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bayer_pattern_pixel: combinational (x, y, pattern) -> 10-bit raw Bayer value.
// Rev 1.0
// ----------------------------------------------------------------------------
module bayer_pattern_pixel
  import isp_pkg::*;
#(
  parameter int          IMG_WIDTH  = 1920,
  parameter logic [31:0] BAYER_MODE = "BGGR"
) (
  input  logic [11:0] x_i,
  input  logic [9:0]  y_i,
  input  pattern_e    pattern_i,
  output logic [9:0]  pix_o
);

  localparam int BAR_W = IMG_WIDTH / 8;

  logic [2:0] bar;
  logic       bar_on;
  cfa_e       site;

  // Smallest bar whose right edge lies beyond x wins; no divider needed.
  always_comb begin
    bar = 3'd7;
    for (int b = 6; b >= 0; b--) begin
      if (x_i < 12'((b + 1) * BAR_W)) bar = 3'(b);
    end
  end

  assign site = cfa_site(BAYER_MODE, y_i[0], x_i[0]);

  always_comb begin
    unique case (site)
      CFA_R:   bar_on = BAR_R_MASK[bar];
      CFA_G:   bar_on = BAR_G_MASK[bar];
      default: bar_on = BAR_B_MASK[bar];
    endcase
  end

  always_comb begin
    unique case (pattern_i)
      PAT_BARS:  pix_o = bar_on ? PIX_ON : PIX_OFF;
      PAT_RAMP:  pix_o = x_i[9:0] + y_i;
      PAT_CHECK: pix_o = (x_i[5] ^ y_i[5]) ? PIX_ON : PIX_OFF;
      default:   pix_o = PIX_FLAT;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/raw_bayer_pattern_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// raw_bayer_pattern_gen: synthetic 10-bit Bayer AXI4-Stream source, 4 px/beat.
// Rev 1.0
// ----------------------------------------------------------------------------
module raw_bayer_pattern_gen
  import isp_pkg::*;
#(
  parameter int          IMG_WIDTH  = 1920,
  parameter int          IMG_HEIGHT = 1080,
  parameter logic [31:0] BAYER_MODE = "BGGR",
  parameter int          H_BLANK    = 16,
  parameter int          V_BLANK    = 1000,
  parameter int          TDEST      = 0
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_enable,
  input  logic [1:0]  I_pattern,
  output logic [39:0] O_tdata,
  output logic        O_tvalid,
  input  logic        O_tready,
  output logic        O_tuser,
  output logic        O_tlast,
  output logic [9:0]  O_tdest,
  output logic [15:0] O_frame_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2,
    ST_VBLANK = 2'd3
  } state_e;

  localparam int          BLANK_MAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int          CNT_W     = (BLANK_MAX > 2) ? $clog2(BLANK_MAX) : 1;
  localparam logic [CNT_W-1:0] HB_LAST = CNT_W'((H_BLANK > 0) ? H_BLANK - 1 : 0);
  localparam logic [CNT_W-1:0] VB_LAST = CNT_W'((V_BLANK > 0) ? V_BLANK - 1 : 0);
  localparam logic [11:0] X_LAST    = 12'(IMG_WIDTH - 4);
  localparam logic [10:0] Y_LAST    = 11'(IMG_HEIGHT - 1);

  state_e            state_q, state_d;
  logic [11:0]       x_q, x_d;
  logic [10:0]       y_q, y_d;
  pattern_e          pat_q, pat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [39:0]       tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d;
  logic              tuser_q, tuser_d;
  logic              tlast_q, tlast_d;
  logic              frame_done, start_frame;
  logic [3:0][9:0]   lane_pix;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    pat_d       = pat_q;
    cnt_d       = cnt_q;
    frame_cnt_d = frame_cnt_q;
    frame_done  = 1'b0;
    start_frame = 1'b0;
    unique case (state_q)
      ST_IDLE: start_frame = I_enable;
      ST_ACTIVE: begin
        if (tvalid_q && O_tready) begin
          if (x_q != X_LAST) begin
            x_d = x_q + 12'd4;
          end else if (y_q == Y_LAST) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (V_BLANK == 0) frame_done = 1'b1;
            else begin
              state_d = ST_VBLANK;
              cnt_d   = '0;
            end
          end else if (H_BLANK == 0) begin
            x_d = '0;
            y_d = y_q + 11'd1;
          end else begin
            state_d = ST_HBLANK;
            cnt_d   = '0;
          end
        end
      end
      ST_HBLANK: begin
        if (cnt_q == HB_LAST) begin
          state_d = ST_ACTIVE;
          x_d     = '0;
          y_d     = y_q + 11'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_VBLANK: begin
        if (cnt_q == VB_LAST) frame_done = 1'b1;
        else cnt_d = cnt_q + 1'b1;
      end
    endcase

    // Enable is only consulted here, so a frame in flight always completes.
    if (frame_done) begin
      if (I_enable) start_frame = 1'b1;
      else state_d = ST_IDLE;
    end
    if (start_frame) begin
      state_d = ST_ACTIVE;
      x_d     = '0;
      y_d     = '0;
      pat_d   = pattern_e'(I_pattern);
    end
  end

  // Pixels are generated for the next-state position so the output registers
  // hold exactly the beat that x_q/y_q point at, stable across stalls.
  for (genvar l = 0; l < 4; l++) begin : g_lane
    bayer_pattern_pixel #(
      .IMG_WIDTH (IMG_WIDTH),
      .BAYER_MODE(BAYER_MODE)
    ) u_pix (
      .x_i      ({x_d[11:2], 2'(l)}),
      .y_i      (y_d[9:0]),
      .pattern_i(pat_d),
      .pix_o    (lane_pix[l])
    );
  end

  always_comb begin
    tvalid_d = (state_d == ST_ACTIVE);
    tuser_d  = tvalid_d && (x_d == 12'd0) && (y_d == 11'd0);
    tlast_d  = tvalid_d && (x_d == X_LAST);
    tdata_d  = tvalid_d ? lane_pix : 40'd0;
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      pat_q       <= PAT_BARS;
      cnt_q       <= '0;
      frame_cnt_q <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tuser_q     <= 1'b0;
      tlast_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      pat_q       <= pat_d;
      cnt_q       <= cnt_d;
      frame_cnt_q <= frame_cnt_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tuser_q     <= tuser_d;
      tlast_q     <= tlast_d;
    end
  end

  assign O_tdata     = tdata_q;
  assign O_tvalid    = tvalid_q;
  assign O_tuser     = tuser_q;
  assign O_tlast     = tlast_q;
  assign O_tdest     = 10'(TDEST);
  assign O_frame_cnt = frame_cnt_q;

endmodule
`default_nettype wire
